// File: rtl/tt_scan_if.sv
// Truth-table word stream between the scan controller and the checker/collector.
interface tt_scan_if #(
    parameter int NIN  = 8,
    parameter int WORD = 32
);
    logic [WORD-1:0] tt_data;
    logic [NIN-6:0]  tt_index;
    logic            tt_valid;
    logic            tt_ready;

    modport master (output tt_data, output tt_index, output tt_valid, input tt_ready);
    modport slave  (input tt_data, input tt_index, input tt_valid, output tt_ready);
endinterface

// File: rtl/tt_scan_ctrl.sv
// Exhaustive minterm sequencer: drives every input vector into a single-output netlist,
// samples y0 after a settle delay and streams packed 32-minterm truth-table words.
module tt_scan_ctrl #(
    parameter int NIN    = 8,
    parameter int WORD   = 32,
    parameter int SETTLE = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic [NIN-1:0] x_out,
    input  logic           y_in,
    tt_scan_if.master      tt,
    output logic [NIN:0]   ones_count,
    output logic           done
);
    typedef enum logic [1:0] {IDLE, APPLY, EMIT, DONE} state_t;

    localparam logic [3:0]     SETTLE_V = 4'(SETTLE);
    localparam logic [NIN-1:0] VEC_ONE  = NIN'(1);
    localparam logic [NIN:0]   CNT_ONE  = (NIN + 1)'(1);

    state_t          state, next_state;
    logic [NIN-1:0]  vec;
    logic [WORD-1:0] acc;
    logic [3:0]      settle_cnt;
    logic            sample;
    logic            word_full;

    // The sampling edge is the one ending the last held cycle of the current vector.
    assign sample    = (state == APPLY) && (settle_cnt == 4'd0);
    assign word_full = (vec[4:0] == 5'd31);
    assign x_out     = vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = APPLY;
            APPLY:   if (sample && word_full) next_state = EMIT;
            EMIT:    if (tt.tt_ready) next_state = (&vec) ? DONE : APPLY;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        done        = (state == DONE);
        tt.tt_valid = (state == EMIT);
        tt.tt_data  = (state == EMIT) ? acc : '0;
        tt.tt_index = (state == EMIT) ? vec[NIN-1:5] : '0;
    end

    // vec only advances on a non-final sample or on acceptance of a non-final word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec        <= '0;
            acc        <= '0;
            settle_cnt <= '0;
            ones_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec        <= '0;
                        acc        <= '0;
                        ones_count <= '0;
                        settle_cnt <= SETTLE_V;
                    end
                end
                APPLY: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else begin
                        acc[vec[4:0]] <= y_in;
                        if (y_in) ones_count <= ones_count + CNT_ONE;
                        if (!word_full) begin
                            vec        <= vec + VEC_ONE;
                            settle_cnt <= SETTLE_V;
                        end
                    end
                end
                EMIT: begin
                    if (tt.tt_ready && !(&vec)) begin
                        vec        <= vec + VEC_ONE;
                        acc        <= '0;
                        settle_cnt <= SETTLE_V;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tt_scan_ctrl.sv
// Bench for tt_scan_ctrl: two instances (SETTLE=0 and SETTLE=2 behind a 2-stage netlist)
// checked against a truth-table model computed directly from the netlist function.
module tb_tt_scan_ctrl;
    localparam int NIN   = 8;
    localparam int WORDS = 1 << (NIN - 5);

    logic           clk = 1'b0;
    logic           rst, start, ready, sel;
    int             mode;
    logic [255:0]   rand_tt;

    logic [NIN-1:0] x0, x2;
    logic [NIN:0]   ones0, ones2;
    logic           busy0, busy2, done0, done2, y0, y2, p1, p2;
    logic           start0, start2;

    logic [NIN-1:0] obs_x;
    logic [NIN:0]   obs_ones;
    logic [31:0]    obs_data;
    logic [NIN-6:0] obs_index;
    logic           obs_valid, obs_busy, obs_done;

    int compared   = 0;
    int mismatched = 0;

    tt_scan_if #(.NIN(NIN), .WORD(32)) if0 ();
    tt_scan_if #(.NIN(NIN), .WORD(32)) if2 ();

    tt_scan_ctrl #(.NIN(NIN), .WORD(32), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .x_out(x0),
        .y_in(y0), .tt(if0), .ones_count(ones0), .done(done0)
    );

    tt_scan_ctrl #(.NIN(NIN), .WORD(32), .SETTLE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .x_out(x2),
        .y_in(y2), .tt(if2), .ones_count(ones2), .done(done2)
    );

    always #5 clk = ~clk;

    // Netlist functions the scan is run against
    function automatic logic ref_bit(input int m, input logic [NIN-1:0] x, input logic [255:0] tbl);
        case (m)
            0:       ref_bit = x[0];
            1:       ref_bit = x[7];
            2:       ref_bit = x[5] ^ x[6];
            3:       ref_bit = x[1];
            default: ref_bit = tbl[x];
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input int m, input int w, input logic [255:0] tbl);
        logic [31:0] r;
        for (int k = 0; k < 32; k++) r[k] = ref_bit(m, NIN'(w * 32 + k), tbl);
        return r;
    endfunction

    assign y0 = ref_bit(mode, x0, rand_tt);
    always @(posedge clk) begin
        p1 <= ref_bit(mode, x2, rand_tt);
        p2 <= p1;
    end
    assign y2 = p2;

    assign start0       = sel ? 1'b0 : start;
    assign start2       = sel ? start : 1'b0;
    assign if0.tt_ready = ready;
    assign if2.tt_ready = ready;

    assign obs_x     = sel ? x2 : x0;
    assign obs_ones  = sel ? ones2 : ones0;
    assign obs_data  = sel ? if2.tt_data : if0.tt_data;
    assign obs_index = sel ? if2.tt_index : if0.tt_index;
    assign obs_valid = sel ? if2.tt_valid : if0.tt_valid;
    assign obs_busy  = sel ? busy2 : busy0;
    assign obs_done  = sel ? done2 : done0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One full scan: words, indices, stall stability, on-set count, done pulse and latency
    task automatic applyStimulus(input int f_mode, input bit slow, input int stall,
                                 input bit rand_ready, input bit mid_start);
        int          cycles = 0, words_seen = 0, done_seen = 0, stalls = 0;
        int          stall_left = 0, exp_ones = 0, exp_cycles, settle;
        bit          pending = 0;
        logic [31:0] snap_data;
        logic [NIN-1:0] snap_x;
        logic [NIN-6:0] snap_index;

        sel    = slow;
        mode   = f_mode;
        settle = slow ? 2 : 0;
        for (int m = 0; m < (1 << NIN); m++) exp_ones += int'(ref_bit(f_mode, NIN'(m), rand_tt));
        $display("[TB] scan mode=%0d settle=%0d stall=%0d rand_ready=%0d", f_mode, settle, stall, rand_ready);

        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cycles = 1;
        checkOutput("busy_after_start", 64'(obs_busy), 64'd1);

        while (done_seen == 0 && cycles < 4000) begin
            start = (mid_start && cycles == 100) ? 1'b1 : 1'b0;
            if (obs_valid) begin
                if (!pending) begin
                    pending    = 1;
                    stall_left = stall;
                    snap_data  = obs_data;
                    snap_index = obs_index;
                    snap_x     = obs_x;
                    checkOutput($sformatf("word%0d_data", words_seen), 64'(obs_data),
                                64'(ref_word(f_mode, words_seen, rand_tt)));
                    checkOutput($sformatf("word%0d_index", words_seen), 64'(obs_index), 64'(words_seen));
                    checkOutput($sformatf("word%0d_x", words_seen), 64'(obs_x), 64'(words_seen * 32 + 31));
                end else begin
                    checkOutput("stall_data", 64'(obs_data), 64'(snap_data));
                    checkOutput("stall_index", 64'(obs_index), 64'(snap_index));
                    checkOutput("stall_x", 64'(obs_x), 64'(snap_x));
                end
                if (rand_ready) begin
                    ready = 1'($urandom_range(0, 1));
                end else begin
                    ready = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                end
                if (ready) begin
                    pending = 0;
                    words_seen++;
                end else begin
                    stalls++;
                end
            end else begin
                ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (obs_done) done_seen++;
            else begin
                @(posedge clk); #1;
                cycles++;
            end
        end

        exp_cycles = WORDS * (32 * (settle + 1) + 1) + 1 + stalls;
        checkOutput("done_seen", 64'(done_seen), 64'd1);
        checkOutput("scan_cycles", 64'(cycles), 64'(exp_cycles));
        checkOutput("words_emitted", 64'(words_seen), 64'(WORDS));
        checkOutput("ones_count_at_done", 64'(obs_ones), 64'(exp_ones));
        @(posedge clk); #1;
        checkOutput("done_one_pulse", 64'(obs_done), 64'd0);
        checkOutput("busy_idle", 64'(obs_busy), 64'd0);
        checkOutput("ones_count_hold", 64'(obs_ones), 64'(exp_ones));
        checkOutput("valid_idle", 64'(obs_valid), 64'd0);
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        start   = 1'b0;
        ready   = 1'b0;
        sel     = 1'b0;
        mode    = 0;
        rand_tt = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_x", 64'(obs_x), 64'd0);
        checkOutput("rst_data", 64'(obs_data), 64'd0);
        checkOutput("rst_index", 64'(obs_index), 64'd0);
        checkOutput("rst_ones", 64'(obs_ones), 64'd0);
        checkOutput("rst_busy", 64'(obs_busy), 64'd0);
        checkOutput("rst_valid", 64'(obs_valid), 64'd0);
        checkOutput("rst_done", 64'(obs_done), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(0, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(2, 1'b0, 10, 1'b0, 1'b0);
        applyStimulus(3, 1'b1, 0, 1'b0, 1'b0);
        applyStimulus(4, 1'b0, 0, 1'b1, 1'b0);
        applyStimulus(4, 1'b1, 0, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 0, 1'b0, 1'b1);

        // Abort a scan partway through word 3 with an asynchronous reset
        $display("[TB] reset during word 3");
        sel   = 1'b0;
        mode  = 0;
        ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (obs_x != NIN'(3 * 32 + 10) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("reach_word3", 64'(obs_x), 64'(3 * 32 + 10));
        #3 rst = 1'b1;
        #1;
        checkOutput("abort_x", 64'(obs_x), 64'd0);
        checkOutput("abort_ones", 64'(obs_ones), 64'd0);
        checkOutput("abort_busy", 64'(obs_busy), 64'd0);
        checkOutput("abort_valid", 64'(obs_valid), 64'd0);
        checkOutput("abort_done", 64'(obs_done), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("abort_hold_valid", 64'(obs_valid), 64'd0);
            checkOutput("abort_hold_done", 64'(obs_done), 64'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(4, 1'b0, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
